// File: rtl/rs_alu.sv
// rs_alu: reservation station feeding the integer ALU.
// Buffers issued ALU micro-ops, snoops both CDB ports to resolve operand
// tags, and dispatches the lowest-index ready entry into a registered bundle.
//
// Dispatch handshake: alu_run_flg is a one-cycle valid pulse with no ready
// back-pressure. The ALU consumes the bundle in the cycle the pulse is high.
// Issue side: iss_flg is accepted only while rs_full is low. An issue while
// full is dropped, so upstream must gate iss_flg with rs_full.
module rs_alu #(
  parameter int RS_SZ      = 16,
  parameter int ROB_SZ_LOG = 4,
  parameter int TAG_W      = ROB_SZ_LOG + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             iss_flg,
  input  logic [3:0]       iss_opcode,
  input  logic [3:0]       iss_optype,
  input  logic [31:0]      iss_vj,
  input  logic [31:0]      iss_vk,
  input  logic             iss_qj_flg,
  input  logic             iss_qk_flg,
  input  logic [TAG_W-1:0] iss_qj,
  input  logic [TAG_W-1:0] iss_qk,
  input  logic [31:0]      iss_imm,
  input  logic [31:0]      iss_pc,
  input  logic [TAG_W-1:0] iss_rd,
  output logic             rs_full,
  input  logic             cdb_alu_flg,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_flg,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_val,
  output logic             alu_run_flg,
  output logic [TAG_W-1:0] alu_rd,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_optype
);

  localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;

  // Entry storage
  logic [RS_SZ-1:0] busy;
  logic [RS_SZ-1:0] qj_flg;
  logic [RS_SZ-1:0] qk_flg;
  logic [3:0]       e_opcode [RS_SZ];
  logic [3:0]       e_optype [RS_SZ];
  logic [31:0]      e_vj     [RS_SZ];
  logic [31:0]      e_vk     [RS_SZ];
  logic [TAG_W-1:0] e_qj     [RS_SZ];
  logic [TAG_W-1:0] e_qk     [RS_SZ];
  logic [31:0]      e_imm    [RS_SZ];
  logic [31:0]      e_pc     [RS_SZ];
  logic [TAG_W-1:0] e_rd     [RS_SZ];

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_hit;
  logic [31:0]      byp_vj;
  logic [31:0]      byp_vk;
  logic             byp_qj_flg;
  logic             byp_qk_flg;

  // Full when every entry is busy; a same-cycle dispatch does not count.
  assign rs_full = &busy;

  // Lowest-index free entry and lowest-index ready entry, from registered state.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    sel_hit  = 1'b0;
    for (int i = RS_SZ - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (busy[i] && !qj_flg[i] && !qk_flg[i]) begin
        sel_idx = IDX_W'(i);
        sel_hit = 1'b1;
      end
    end
  end

  // Issue bypass: capture a value broadcast in the issue cycle itself.
  // The ALU port is checked first so it wins an (illegal) double match.
  always_comb begin
    byp_vj     = iss_vj;
    byp_qj_flg = iss_qj_flg;
    byp_vk     = iss_vk;
    byp_qk_flg = iss_qk_flg;
    if (iss_qj_flg) begin
      if (cdb_alu_flg && cdb_alu_tag == iss_qj) begin
        byp_vj = cdb_alu_val; byp_qj_flg = 1'b0;
      end else if (cdb_lsb_flg && cdb_lsb_tag == iss_qj) begin
        byp_vj = cdb_lsb_val; byp_qj_flg = 1'b0;
      end
    end
    if (iss_qk_flg) begin
      if (cdb_alu_flg && cdb_alu_tag == iss_qk) begin
        byp_vk = cdb_alu_val; byp_qk_flg = 1'b0;
      end else if (cdb_lsb_flg && cdb_lsb_tag == iss_qk) begin
        byp_vk = cdb_lsb_val; byp_qk_flg = 1'b0;
      end
    end
  end

  // Entry state and dispatch bundle: reset > flush > stall > normal.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy        <= '0;
      qj_flg      <= '0;
      qk_flg      <= '0;
      alu_run_flg <= 1'b0;
      alu_rd      <= '0;
      alu_vj      <= '0;
      alu_vk      <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_opcode  <= '0;
      alu_optype  <= '0;
    end else if (clr_in) begin
      busy        <= '0;
      alu_run_flg <= 1'b0;
    end else if (!rdy_in) begin
      // Drop the pulse so the held bundle is not executed twice.
      alu_run_flg <= 1'b0;
    end else begin
      // Wakeup of waiting operands in busy entries.
      for (int i = 0; i < RS_SZ; i++) begin
        if (busy[i] && qj_flg[i]) begin
          if (cdb_alu_flg && cdb_alu_tag == e_qj[i]) begin
            e_vj[i] <= cdb_alu_val; qj_flg[i] <= 1'b0;
          end else if (cdb_lsb_flg && cdb_lsb_tag == e_qj[i]) begin
            e_vj[i] <= cdb_lsb_val; qj_flg[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_flg[i]) begin
          if (cdb_alu_flg && cdb_alu_tag == e_qk[i]) begin
            e_vk[i] <= cdb_alu_val; qk_flg[i] <= 1'b0;
          end else if (cdb_lsb_flg && cdb_lsb_tag == e_qk[i]) begin
            e_vk[i] <= cdb_lsb_val; qk_flg[i] <= 1'b0;
          end
        end
      end
      // Dispatch the selected entry; the freed slot is reusable next cycle.
      alu_run_flg <= sel_hit;
      if (sel_hit) begin
        busy[sel_idx] <= 1'b0;
        alu_rd        <= e_rd[sel_idx];
        alu_vj        <= e_vj[sel_idx];
        alu_vk        <= e_vk[sel_idx];
        alu_imm       <= e_imm[sel_idx];
        alu_pc        <= e_pc[sel_idx];
        alu_opcode    <= e_opcode[sel_idx];
        alu_optype    <= e_optype[sel_idx];
      end
      // Issue into the lowest free slot (never the slot being dispatched).
      if (iss_flg && !rs_full) begin
        busy[free_idx]     <= 1'b1;
        e_opcode[free_idx] <= iss_opcode;
        e_optype[free_idx] <= iss_optype;
        e_vj[free_idx]     <= byp_vj;
        e_vk[free_idx]     <= byp_vk;
        qj_flg[free_idx]   <= byp_qj_flg;
        qk_flg[free_idx]   <= byp_qk_flg;
        e_qj[free_idx]     <= iss_qj;
        e_qk[free_idx]     <= iss_qk;
        e_imm[free_idx]    <= iss_imm;
        e_pc[free_idx]     <= iss_pc;
        e_rd[free_idx]     <= iss_rd;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: scoreboard bench for rs_alu. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_rs_alu;

  localparam int RS_SZ = 16;
  localparam int TAG_W = 5;
  localparam int W     = TAG_W + 32 * 4 + 8;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clr_in, iss_flg;
  logic [3:0]       iss_opcode, iss_optype;
  logic [31:0]      iss_vj, iss_vk, iss_imm, iss_pc;
  logic             iss_qj_flg, iss_qk_flg;
  logic [TAG_W-1:0] iss_qj, iss_qk, iss_rd;
  logic             rs_full;
  logic             cdb_alu_flg, cdb_lsb_flg;
  logic [TAG_W-1:0] cdb_alu_tag, cdb_lsb_tag;
  logic [31:0]      cdb_alu_val, cdb_lsb_val;
  logic             alu_run_flg;
  logic [TAG_W-1:0] alu_rd;
  logic [31:0]      alu_vj, alu_vk, alu_imm, alu_pc;
  logic [3:0]       alu_opcode, alu_optype;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rs_alu #(.RS_SZ(RS_SZ), .ROB_SZ_LOG(4), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .iss_flg(iss_flg), .iss_opcode(iss_opcode), .iss_optype(iss_optype),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj_flg(iss_qj_flg),
    .iss_qk_flg(iss_qk_flg), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rd(iss_rd), .rs_full(rs_full),
    .cdb_alu_flg(cdb_alu_flg), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_flg(cdb_lsb_flg), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
    .alu_run_flg(alu_run_flg), .alu_rd(alu_rd), .alu_vj(alu_vj), .alu_vk(alu_vk),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_opcode(alu_opcode), .alu_optype(alu_optype)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] pack(input logic [TAG_W-1:0] rd,
      input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
      input logic [31:0] pc, input logic [3:0] op, input logic [3:0] ty);
    return {rd, vj, vk, imm, pc, op, ty};
  endfunction

  // Advance one cycle; every dispatch pulse is matched against the queue.
  task automatic tick();
    logic [W-1:0] got, exp;
    @(negedge clk_in);
    if (alu_run_flg === 1'b1) begin
      got = pack(alu_rd, alu_vj, alu_vk, alu_imm, alu_pc, alu_opcode, alu_optype);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dispatch got rd=%0d vj=%h vk=%h expected no dispatch",
                 alu_rd, alu_vj, alu_vk);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL dispatch_bundle got %h expected %h", got, exp);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    iss_flg = 1'b0; iss_opcode = '0; iss_optype = '0; iss_vj = '0; iss_vk = '0;
    iss_qj_flg = 1'b0; iss_qk_flg = 1'b0; iss_qj = '0; iss_qk = '0;
    iss_imm = '0; iss_pc = '0; iss_rd = '0;
    cdb_alu_flg = 1'b0; cdb_alu_tag = '0; cdb_alu_val = '0;
    cdb_lsb_flg = 1'b0; cdb_lsb_tag = '0; cdb_lsb_val = '0;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [3:0] ty,
      input logic [31:0] vj, input logic jf, input logic [TAG_W-1:0] qj,
      input logic [31:0] vk, input logic kf, input logic [TAG_W-1:0] qk,
      input logic [31:0] imm, input logic [31:0] pc, input logic [TAG_W-1:0] rd);
    iss_flg = 1'b1; iss_opcode = op; iss_optype = ty;
    iss_vj = vj; iss_qj_flg = jf; iss_qj = qj;
    iss_vk = vk; iss_qk_flg = kf; iss_qk = qk;
    iss_imm = imm; iss_pc = pc; iss_rd = rd;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_dispatch got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    idle_inputs();
    set_issue(4'h1, 4'h2, 32'd1, 1'b0, '0, 32'd2, 1'b0, '0, 32'd3, 32'h100, 5'd1);
    tick(); tick();
    checks++;
    if (alu_run_flg !== 1'b0 || rs_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got run=%b full=%b expected 0 0", alu_run_flg, rs_full);
    end
    checks++;
    if ({alu_rd, alu_vj, alu_vk, alu_imm, alu_pc, alu_opcode, alu_optype} !== '0) begin
      errors++;
      $display("FAIL reset_bundle got rd=%h vj=%h vk=%h imm=%h pc=%h expected all 0",
               alu_rd, alu_vj, alu_vk, alu_imm, alu_pc);
    end
    idle_inputs();
    rst_in = 1'b1;
    repeat (3) tick();
    check_drained("reset");
  endtask

  task automatic test_ready_addi();
    set_issue(4'h1, 4'h2, 32'd5, 1'b0, '0, 32'd0, 1'b0, '0, 32'd7, 32'h200, 5'd3);
    exp_q.push_back(pack(5'd3, 32'd5, 32'd0, 32'd7, 32'h200, 4'h1, 4'h2));
    tick();
    idle_inputs();
    tick();
    checks++;
    if (alu_run_flg !== 1'b1 || alu_vj !== 32'd5 || alu_imm !== 32'd7 || alu_rd !== 5'd3) begin
      errors++;
      $display("FAIL addi_dispatch got run=%b vj=%0d imm=%0d rd=%0d expected 1 5 7 3",
               alu_run_flg, alu_vj, alu_imm, alu_rd);
    end
    tick();
    checks++;
    if (alu_run_flg !== 1'b0) begin
      errors++;
      $display("FAIL addi_pulse_width got run=%b expected 0", alu_run_flg);
    end
    check_drained("addi");
  endtask

  task automatic test_wakeup();
    // Operand j waits on tag 4, resolved by an LSB broadcast later.
    set_issue(4'h0, 4'h1, 32'hdead, 1'b1, 5'd4, 32'd10, 1'b0, '0, 32'd0, 32'h300, 5'd6);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (alu_run_flg !== 1'b0) begin
        errors++;
        $display("FAIL wakeup_early got run=%b expected 0", alu_run_flg);
      end
    end
    cdb_lsb_flg = 1'b1; cdb_lsb_tag = 5'd4; cdb_lsb_val = 32'h20;
    exp_q.push_back(pack(5'd6, 32'h20, 32'd10, 32'd0, 32'h300, 4'h0, 4'h1));
    tick();
    idle_inputs();
    checks++;
    if (alu_run_flg !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_same_edge got run=%b expected 0", alu_run_flg);
    end
    tick();
    checks++;
    if (alu_run_flg !== 1'b1 || alu_vj !== 32'h20 || alu_vk !== 32'd10) begin
      errors++;
      $display("FAIL wakeup_dispatch got run=%b vj=%h vk=%0d expected 1 20 10",
               alu_run_flg, alu_vj, alu_vk);
    end
    tick();
    check_drained("wakeup");
  endtask

  task automatic test_bypass();
    // j bypassed from LSB, k bypassed from ALU port in the issue cycle.
    set_issue(4'h0, 4'h3, 32'h0, 1'b1, 5'd4, 32'h0, 1'b1, 5'd11, 32'd1, 32'h400, 5'd7);
    cdb_lsb_flg = 1'b1; cdb_lsb_tag = 5'd4; cdb_lsb_val = 32'h20;
    cdb_alu_flg = 1'b1; cdb_alu_tag = 5'd11; cdb_alu_val = 32'h55;
    exp_q.push_back(pack(5'd7, 32'h20, 32'h55, 32'd1, 32'h400, 4'h0, 4'h3));
    tick();
    idle_inputs();
    tick();
    checks++;
    if (alu_run_flg !== 1'b1 || alu_vj !== 32'h20 || alu_vk !== 32'h55) begin
      errors++;
      $display("FAIL bypass_dispatch got run=%b vj=%h vk=%h expected 1 20 55",
               alu_run_flg, alu_vj, alu_vk);
    end
    // qj == qk: both operands wake from one broadcast.
    set_issue(4'h2, 4'h0, 32'h0, 1'b1, 5'd13, 32'h0, 1'b1, 5'd13, 32'd2, 32'h404, 5'd8);
    tick();
    idle_inputs();
    cdb_alu_flg = 1'b1; cdb_alu_tag = 5'd13; cdb_alu_val = 32'h77;
    exp_q.push_back(pack(5'd8, 32'h77, 32'h77, 32'd2, 32'h404, 4'h2, 4'h0));
    tick();
    idle_inputs();
    tick();
    checks++;
    if (alu_run_flg !== 1'b1) begin
      errors++;
      $display("FAIL same_tag_wakeup got run=%b expected 1", alu_run_flg);
    end
    tick();
    check_drained("bypass");
  endtask

  task automatic test_full_order();
    logic [31:0] v;
    v = $urandom_range(1, 32'hffff);
    for (int i = 0; i < RS_SZ; i++) begin
      set_issue(4'h4, 4'h1, 32'h0, 1'b1, 5'd9, 32'(i * 3 + 1), 1'b0, '0,
                32'(i), 32'h1000 + 32'(i * 4), 5'(i));
      tick();
    end
    idle_inputs();
    checks++;
    if (rs_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set got rs_full=%b expected 1", rs_full);
    end
    // Dropped issue: would be ready, so any dispatch of rd=20 is caught.
    set_issue(4'h1, 4'h1, 32'd1, 1'b0, '0, 32'd1, 1'b0, '0, 32'd0, 32'h0, 5'd20);
    tick();
    idle_inputs();
    cdb_alu_flg = 1'b1; cdb_alu_tag = 5'd9; cdb_alu_val = v;
    for (int i = 0; i < RS_SZ; i++)
      exp_q.push_back(pack(5'(i), v, 32'(i * 3 + 1), 32'(i), 32'h1000 + 32'(i * 4), 4'h4, 4'h1));
    tick();
    idle_inputs();
    checks++;
    if (rs_full !== 1'b1 || alu_run_flg !== 1'b0) begin
      errors++;
      $display("FAIL full_wake_edge got full=%b run=%b expected 1 0", rs_full, alu_run_flg);
    end
    for (int i = 0; i < RS_SZ; i++) begin
      tick();
      checks++;
      if (alu_run_flg !== 1'b1 || (i == 0 && rs_full !== 1'b0)) begin
        errors++;
        $display("FAIL full_drain step=%0d got run=%b full=%b expected 1 0",
                 i, alu_run_flg, rs_full);
      end
    end
    repeat (2) tick();
    check_drained("full");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_issue(4'h5, 4'h0, 32'h0, 1'b1, 5'd12, 32'd1, 1'b0, '0, 32'd0, 32'h0, 5'(i));
      tick();
    end
    idle_inputs();
    cdb_lsb_flg = 1'b1; cdb_lsb_tag = 5'd12; cdb_lsb_val = 32'h9;
    tick();
    idle_inputs();
    clr_in = 1'b1;
    set_issue(4'h1, 4'h1, 32'd3, 1'b0, '0, 32'd4, 1'b0, '0, 32'd0, 32'h0, 5'd15);
    tick();
    idle_inputs();
    clr_in = 1'b0;
    checks++;
    if (alu_run_flg !== 1'b0 || rs_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_edge got run=%b full=%b expected 0 0", alu_run_flg, rs_full);
    end
    repeat (5) tick();
    check_drained("flush");
  endtask

  task automatic test_stall();
    set_issue(4'h6, 4'h2, 32'd11, 1'b0, '0, 32'd12, 1'b0, '0, 32'd13, 32'h500, 5'd2);
    tick();
    idle_inputs();
    rdy_in = 1'b0;
    exp_q.push_back(pack(5'd2, 32'd11, 32'd12, 32'd13, 32'h500, 4'h6, 4'h2));
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (alu_run_flg !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got run=%b expected 0", i, alu_run_flg);
      end
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (alu_run_flg !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume got run=%b expected 1", alu_run_flg);
    end
    tick();
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom(); b = $urandom();
      set_issue(4'(i), 4'(7 - i), a, 1'b0, '0, b, 1'b0, '0, 32'(i), 32'h600 + 32'(i), 5'(i + 16));
      exp_q.push_back(pack(5'(i + 16), a, b, 32'(i), 32'h600 + 32'(i), 4'(i), 4'(7 - i)));
      tick();
      if (i > 0) begin
        checks++;
        if (alu_run_flg !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back step=%0d got run=%b expected 1", i, alu_run_flg);
        end
      end
    end
    idle_inputs();
    repeat (2) tick();
    check_drained("b2b");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      set_issue(4'h3, 4'h3, 32'h0, 1'b1, 5'd14, 32'd1, 1'b0, '0, 32'd0, 32'h0, 5'(i));
      tick();
    end
    idle_inputs();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    checks++;
    if (alu_run_flg !== 1'b0 || alu_rd !== '0 || alu_vj !== '0 || alu_pc !== '0) begin
      errors++;
      $display("FAIL reset_mid got run=%b rd=%0d vj=%h pc=%h expected zeros",
               alu_run_flg, alu_rd, alu_vj, alu_pc);
    end
    cdb_alu_flg = 1'b1; cdb_alu_tag = 5'd14; cdb_alu_val = 32'h1;
    tick();
    idle_inputs();
    repeat (3) tick();
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_ready_addi();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
